// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the CPU MEM stage and the host loader port.
// Round-robin arbitration with a capped host burst; read data is routed back to its owner.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CPU_OWN  = 2'd1;
  localparam logic [1:0] HOST_OWN = 2'd2;
  localparam int unsigned CNT_W   = 8;

  logic [1:0]        last, last_nxt;
  logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt;
  logic              cpu_win, host_win;
  logic [RD_LAT-1:0] tag_vld, tag_host;
  logic              issue_rd, ret_vld;
  logic [DATA_W-1:0] cpu_hold, host_hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last      <= IDLE;
      burst_cnt <= '0;
    end else begin
      last      <= last_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Same-cycle arbitration, next-owner tracking and issue mux
  always_comb begin
    cpu_win       = 1'b0;
    host_win      = 1'b0;
    last_nxt      = IDLE;
    burst_cnt_nxt = '0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (reset) begin
      if (cpu_req && host_req) begin
        case (last)
          CPU_OWN:  host_win = 1'b1;
          HOST_OWN: begin
            if (burst_cnt < CNT_W'(MAX_BURST)) host_win = 1'b1;
            else                               cpu_win  = 1'b1;
          end
          default:  cpu_win = 1'b1;
        endcase
      end else begin
        cpu_win  = cpu_req;
        host_win = host_req;
      end
    end
    if (cpu_win) begin
      last_nxt  = CPU_OWN;
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (host_win) begin
      last_nxt      = HOST_OWN;
      burst_cnt_nxt = (burst_cnt == {CNT_W{1'b1}}) ? burst_cnt : burst_cnt + CNT_W'(1);
      mem_en        = 1'b1;
      mem_we        = host_we;
      mem_addr      = host_addr;
      mem_wdata     = host_wdata;
    end
  end

  assign cpu_stall = reset & cpu_req & ~cpu_win;
  assign host_gnt  = host_win;
  assign issue_rd  = mem_en & ~mem_we;

  // Read-tag pipe: one {valid, owner} slot per cycle of RAM latency
  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (!reset) begin
        tag_vld  <= '0;
        tag_host <= '0;
      end else begin
        tag_vld  <= issue_rd;
        tag_host <= host_win;
      end
    end
  end else begin : g_latn
    always_ff @(posedge clk) begin
      if (!reset) begin
        tag_vld  <= '0;
        tag_host <= '0;
      end else begin
        tag_vld  <= {tag_vld[RD_LAT-2:0], issue_rd};
        tag_host <= {tag_host[RD_LAT-2:0], host_win};
      end
    end
  end

  assign ret_vld     = reset & tag_vld[RD_LAT-1];
  assign cpu_rvalid  = ret_vld & ~tag_host[RD_LAT-1];
  assign host_rvalid = ret_vld & tag_host[RD_LAT-1];
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_hold;
  assign host_rdata  = host_rvalid ? mem_rdata : host_hold;

  // Hold registers keep the last delivered word visible between returns
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_hold  <= '0;
      host_hold <= '0;
    end else begin
      if (cpu_rvalid)  cpu_hold  <= mem_rdata;
      if (host_rvalid) host_hold <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance a (RD_LAT=1, MAX_BURST=1) and instance b (RD_LAT=2, MAX_BURST=8)
// share one stimulus stream; each owns a behavioural RAM and a queue-of-returns reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;

  logic [1:0]  o_stall, o_gnt, o_cv, o_hv, o_en, o_we;
  logic [31:0] o_crd [2];
  logic [31:0] o_hrd [2];
  logic [31:0] o_addr [2];
  logic [31:0] o_wd [2];
  logic [31:0] ram_rd [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_BURST(1)) dut_a (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(o_stall[0]), .cpu_rdata(o_crd[0]), .cpu_rvalid(o_cv[0]),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(o_gnt[0]), .host_rdata(o_hrd[0]), .host_rvalid(o_hv[0]),
    .mem_en(o_en[0]), .mem_we(o_we[0]), .mem_addr(o_addr[0]), .mem_wdata(o_wd[0]),
    .mem_rdata(ram_rd[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2), .MAX_BURST(8)) dut_b (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(o_stall[1]), .cpu_rdata(o_crd[1]), .cpu_rvalid(o_cv[1]),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(o_gnt[1]), .host_rdata(o_hrd[1]), .host_rvalid(o_hv[1]),
    .mem_en(o_en[1]), .mem_we(o_we[1]), .mem_addr(o_addr[1]), .mem_wdata(o_wd[1]),
    .mem_rdata(ram_rd[1])
  );

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int mb_of(int i);
    return (i == 0) ? 1 : 8;
  endfunction

  function automatic logic [31:0] init_word(logic [7:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h20:   return 32'h0000_1111;
      8'h24:   return 32'h0000_2222;
      default: return {8'hA5, a, 8'h5A, ~a};
    endcase
  endfunction

  // Behavioural RAMs, word-indexed by address bits [7:0], data RD_LAT cycles after issue
  logic [31:0] ram [2][256];
  bit          ram_wr [2][256];
  logic [31:0] rpipe [2][2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rpipe[i][1] <= rpipe[i][0];
      if (o_en[i] && o_we[i]) begin
        ram[i][o_addr[i][7:0]]    <= o_wd[i];
        ram_wr[i][o_addr[i][7:0]] <= 1'b1;
      end
      if (o_en[i] && !o_we[i])
        rpipe[i][0] <= ram_wr[i][o_addr[i][7:0]] ? ram[i][o_addr[i][7:0]] : init_word(o_addr[i][7:0]);
      else
        rpipe[i][0] <= 32'h0;
    end
  end

  assign ram_rd[0] = rpipe[0][0];
  assign ram_rd[1] = rpipe[1][1];

  // Reference model: owner history, burst length, and returns scheduled by due cycle
  int          cyc = 0;
  int          m_last [2];
  int          m_burst [2];
  logic [31:0] m_mem [2][256];
  bit          s_vld [2][8];
  bit          s_host [2][8];
  logic [31:0] s_data [2][8];
  logic [31:0] m_hold [2][2];

  int          e_win [2];
  logic [1:0]  e_en, e_we, e_stall, e_gnt, e_cv, e_hv;
  logic [31:0] e_addr [2];
  logic [31:0] e_wd [2];
  logic [31:0] e_crd [2];
  logic [31:0] e_hrd [2];

  task automatic model_eval();
    for (int i = 0; i < 2; i++) begin
      int w;
      int sl;
      w  = 0;
      sl = cyc % 8;
      if (reset) begin
        if (cpu_req && !host_req)      w = 1;
        else if (host_req && !cpu_req) w = 2;
        else if (cpu_req && host_req) begin
          if (m_last[i] == 1)                                w = 2;
          else if (m_last[i] == 2 && m_burst[i] < mb_of(i))  w = 2;
          else                                               w = 1;
        end
      end
      e_win[i]   = w;
      e_en[i]    = (w != 0);
      e_we[i]    = (w == 1) ? cpu_we    : (w == 2) ? host_we    : 1'b0;
      e_addr[i]  = (w == 1) ? cpu_addr  : (w == 2) ? host_addr  : 32'h0;
      e_wd[i]    = (w == 1) ? cpu_wdata : (w == 2) ? host_wdata : 32'h0;
      e_stall[i] = reset && cpu_req && (w != 1);
      e_gnt[i]   = (w == 2);
      e_cv[i]    = reset && s_vld[i][sl] && !s_host[i][sl];
      e_hv[i]    = reset && s_vld[i][sl] && s_host[i][sl];
      e_crd[i]   = e_cv[i] ? s_data[i][sl] : m_hold[i][0];
      e_hrd[i]   = e_hv[i] ? s_data[i][sl] : m_hold[i][1];
    end
  endtask

  task automatic model_update();
    model_eval();
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_last[i]    = 0;
        m_burst[i]   = 0;
        m_hold[i][0] = 32'h0;
        m_hold[i][1] = 32'h0;
        for (int k = 0; k < 8; k++) s_vld[i][k] = 1'b0;
      end else begin
        int sl;
        int d;
        sl = cyc % 8;
        if (s_vld[i][sl]) m_hold[i][s_host[i][sl] ? 1 : 0] = s_data[i][sl];
        s_vld[i][sl] = 1'b0;
        if (e_win[i] != 0) begin
          if (e_we[i]) m_mem[i][e_addr[i][7:0]] = e_wd[i];
          else begin
            d = (cyc + lat_of(i)) % 8;
            s_vld[i][d]  = 1'b1;
            s_host[i][d] = (e_win[i] == 2);
            s_data[i][d] = m_mem[i][e_addr[i][7:0]];
          end
        end
        m_last[i]  = e_win[i];
        m_burst[i] = (e_win[i] == 2) ? ((m_burst[i] < 255) ? m_burst[i] + 1 : 255) : 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic idle(int n);
    reset    = 1'b1;
    cpu_req  = 1'b0;
    host_req = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_req = 1'b1; host_req = 1'b1; cpu_we = 1'b0; host_we = 1'b1;
    cpu_addr = 32'h10; host_addr = 32'h20; cpu_wdata = 32'h1; host_wdata = 32'h2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if ({o_en[i], o_we[i], o_stall[i], o_gnt[i], o_cv[i], o_hv[i]} !== 6'b0) begin
          n_err++;
          $display("FAIL reset_ctl inst%0d cycle%0d: got %b want 000000", i, k,
                   {o_en[i], o_we[i], o_stall[i], o_gnt[i], o_cv[i], o_hv[i]});
        end
        n_cmp++;
        if ({o_crd[i], o_hrd[i]} !== 64'h0) begin
          n_err++;
          $display("FAIL reset_rdata inst%0d cycle%0d: got %h/%h want 0/0", i, k, o_crd[i], o_hrd[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_cpu_read();
    idle(2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0; host_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_en[0], o_we[0], o_stall[0]} !== 3'b100 || o_addr[0] !== 32'h10) begin
      n_err++;
      $display("FAIL cpu_rd_issue: got en/we/stall=%b addr=%h want 100 addr=00000010",
               {o_en[0], o_we[0], o_stall[0]}, o_addr[0]);
    end
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_cv[0], o_hv[0]} !== 2'b10 || o_crd[0] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL cpu_rd_ret_lat1: got cv/hv=%b data=%h want 10 deadbeef", {o_cv[0], o_hv[0]}, o_crd[0]);
    end
    n_cmp++;
    if (o_cv[1] !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_rd_early_lat2: got cpu_rvalid=%b want 0", o_cv[1]);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({o_cv[1], o_hv[1]} !== 2'b10 || o_crd[1] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL cpu_rd_ret_lat2: got cv/hv=%b data=%h want 10 deadbeef", {o_cv[1], o_hv[1]}, o_crd[1]);
    end
    n_cmp++;
    if (o_cv[0] !== 1'b0 || o_crd[0] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL cpu_rd_hold_lat1: got cv=%b data=%h want 0 deadbeef", o_cv[0], o_crd[0]);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic odd;
    idle(3);
    cpu_req = 1'b1; host_req = 1'b1; cpu_we = 1'b0; host_we = 1'b0;
    cpu_addr = 32'h30; host_addr = 32'h34;
    for (int k = 0; k < 4; k++) begin
      odd = (k % 2 == 1);
      @(negedge clk);
      n_cmp++;
      if ({o_en[0], o_gnt[0], o_stall[0]} !== {1'b1, odd, odd}) begin
        n_err++;
        $display("FAIL round_robin cycle%0d: got en/gnt/stall=%b want %b", k + 1,
                 {o_en[0], o_gnt[0], o_stall[0]}, {1'b1, odd, odd});
      end
      tick();
    end
  endtask

  task automatic test_burst_cap();
    logic want_gnt, want_stall;
    idle(3);
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h40; cpu_we = 1'b0; cpu_addr = 32'h44;
    for (int k = 0; k < 13; k++) begin
      cpu_req    = (k >= 3 && k <= 8);
      want_gnt   = (k != 8);
      want_stall = (k >= 3 && k <= 7);
      @(negedge clk);
      n_cmp++;
      if ({o_en[1], o_gnt[1], o_stall[1]} !== {1'b1, want_gnt, want_stall}) begin
        n_err++;
        $display("FAIL burst_cap cycle%0d: got en/gnt/stall=%b want %b", k,
                 {o_en[1], o_gnt[1], o_stall[1]}, {1'b1, want_gnt, want_stall});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    idle(3);
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h20;
    @(negedge clk);
    tick();
    host_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h24;
    @(negedge clk);
    n_cmp++;
    if (o_hv[0] !== 1'b1 || o_hrd[0] !== 32'h1111 || o_hv[1] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_n1: got a.hv=%b a.hrd=%h b.hv=%b want 1 00001111 0", o_hv[0], o_hrd[0], o_hv[1]);
    end
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_hv[1], o_cv[1]} !== 2'b10 || o_hrd[1] !== 32'h1111) begin
      n_err++;
      $display("FAIL b2b_n2_host: got hv/cv=%b hrd=%h want 10 00001111", {o_hv[1], o_cv[1]}, o_hrd[1]);
    end
    n_cmp++;
    if (o_cv[0] !== 1'b1 || o_crd[0] !== 32'h2222) begin
      n_err++;
      $display("FAIL b2b_n2_lat1_cpu: got cv=%b crd=%h want 1 00002222", o_cv[0], o_crd[0]);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({o_hv[1], o_cv[1]} !== 2'b01 || o_crd[1] !== 32'h2222) begin
      n_err++;
      $display("FAIL b2b_n3_cpu: got hv/cv=%b crd=%h want 01 00002222", {o_hv[1], o_cv[1]}, o_crd[1]);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({o_hv[1], o_cv[1]} !== 2'b00 || o_hrd[1] !== 32'h1111 || o_crd[1] !== 32'h2222) begin
      n_err++;
      $display("FAIL b2b_n4_hold: got hv/cv=%b hrd=%h crd=%h want 00 00001111 00002222",
               {o_hv[1], o_cv[1]}, o_hrd[1], o_crd[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    idle(2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    @(negedge clk);
    n_cmp++;
    if (o_en[1] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_issue: got mem_en=%b want 1", o_en[1]);
    end
    tick();
    cpu_req = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_cv[0], o_cv[1]} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid_n1: got cpu_rvalid a/b=%b want 00", {o_cv[0], o_cv[1]});
    end
    tick();
    reset = 1'b1;
    for (int k = 2; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_cv[0], o_cv[1]} !== 2'b00 || o_crd[0] !== 32'h0 || o_crd[1] !== 32'h0) begin
        n_err++;
        $display("FAIL rst_mid_n%0d: got cv a/b=%b crd a=%h b=%h want 00 0 0", k,
                 {o_cv[0], o_cv[1]}, o_crd[0], o_crd[1]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 59) != 0);
      cpu_req    = 1'($urandom_range(0, 1));
      cpu_we     = ($urandom_range(0, 2) == 0);
      cpu_addr   = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
      cpu_wdata  = $urandom();
      host_req   = ($urandom_range(0, 3) != 0);
      host_we    = ($urandom_range(0, 2) == 0);
      host_addr  = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
      host_wdata = $urandom();
      @(negedge clk);
      model_eval();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if ({o_en[i], o_we[i], o_stall[i], o_gnt[i], o_cv[i], o_hv[i]} !==
            {e_en[i], e_we[i], e_stall[i], e_gnt[i], e_cv[i], e_hv[i]}) begin
          n_err++;
          $display("FAIL rand_ctl inst%0d step%0d: got en/we/stall/gnt/cv/hv=%b want %b", i, n,
                   {o_en[i], o_we[i], o_stall[i], o_gnt[i], o_cv[i], o_hv[i]},
                   {e_en[i], e_we[i], e_stall[i], e_gnt[i], e_cv[i], e_hv[i]});
        end
        n_cmp++;
        if ({o_addr[i], o_wd[i]} !== {e_addr[i], e_wd[i]}) begin
          n_err++;
          $display("FAIL rand_issue inst%0d step%0d: got addr=%h wdata=%h want %h %h", i, n,
                   o_addr[i], o_wd[i], e_addr[i], e_wd[i]);
        end
        n_cmp++;
        if ({o_crd[i], o_hrd[i]} !== {e_crd[i], e_hrd[i]}) begin
          n_err++;
          $display("FAIL rand_rdata inst%0d step%0d: got cpu=%h host=%h want %h %h", i, n,
                   o_crd[i], o_hrd[i], e_crd[i], e_hrd[i]);
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_last[i]    = 0;
      m_burst[i]   = 0;
      m_hold[i][0] = 32'h0;
      m_hold[i][1] = 32'h0;
      for (int k = 0; k < 8; k++) s_vld[i][k] = 1'b0;
      for (int a = 0; a < 256; a++) m_mem[i][a] = init_word(8'(a));
    end
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_burst_cap();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port data memory between the pipelined CPU's MEM stage and a host loader port. The host loader writes RSA keys and messages and reads back results.
- Sits between the EX/MEM pipeline register outputs and the data RAM.
- Issues at most one access per cycle, with bounded host bursts and round-robin fairness.
- Returns read data to the owner of each read after a fixed RAM latency, and drives a stall to the CPU pipeline while the CPU is denied.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RD_LAT, 1, RAM read latency in cycles (1..4)
MAX_BURST, 8, maximum consecutive host grants while the CPU is waiting (1..255)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous reset, active-low
cpu_req  in  1  CPU access request (MEM stage)
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  CPU request pending but not granted this cycle
cpu_rdata  out  DATA_W  CPU read data
cpu_rvalid  out  1  cpu_rdata valid (1-cycle pulse)
host_req  in  1  host access request
host_we  in  1  host write / read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host request accepted this cycle
host_rdata  out  DATA_W  host read data
host_rvalid  out  1  host_rdata valid (1-cycle pulse)
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after issue

Behaviour:
- The clock is clk; reset is synchronous and active-low. While reset=0, at the next edge:
  - state <= IDLE, burst_cnt <= 0
  - read-tag pipe cleared, rdata hold registers <= 0
- Outputs while reset=0: all grants, cpu_stall, mem_en, mem_we, and both rvalid outputs are 0. Both rdata outputs are 0 from the first edge onward.
- State register `last`, holding the previous cycle's winner: IDLE (no grant), CPU_OWN, HOST_OWN.
- Arbitration is combinational in the same cycle, from the requests, `last` and burst_cnt:
  - cpu_req only: CPU wins.
  - host_req only: host wins.
  - Both, last=IDLE: CPU wins.
  - Both, last=CPU_OWN: host wins (round-robin).
  - Both, last=HOST_OWN and burst_cnt<MAX_BURST: host wins.
  - Both, last=HOST_OWN and burst_cnt>=MAX_BURST: CPU wins.
  - Neither: no grant; mem_en=0.
- Next-state rules:
  - `last` <= the winner, or IDLE if there is no grant.
  - burst_cnt <= burst_cnt+1 (saturating at 255) on a host grant, else 0.
  - A host grant with cpu_req=0 still counts.
- Issue outputs:
  - mem_en = any grant.
  - mem_we/mem_addr/mem_wdata are muxed from the winner, with zero added latency.
  - With no grant, mem_we=0 and mem_addr/mem_wdata are 0.
- cpu_stall = cpu_req & ~cpu_win. host_gnt = host_win. The host must hold its request fields stable until host_gnt=1.
- Read return:
  - A tag pipe of depth RD_LAT shifts {valid, owner} every cycle. It is loaded with valid=1 on a granted read, and valid=0 on a write or idle cycle.
  - At the pipe output, the owner's rvalid=1 and its rdata=mem_rdata in that same cycle. Its hold register captures mem_rdata.
  - Outside rvalid, rdata shows the hold register, i.e. the last delivered value.
- Latency: a read granted in cycle N gives rvalid in cycle N+RD_LAT. Writes produce no rvalid.
- Back-to-back reads from alternating owners return in issue order, one per cycle.
- Reset asserted mid-operation: in-flight tags are discarded and no rvalid is produced for them after reset.
- An address out of RAM range is passed through unchecked.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both requests high -> mem_en=0, cpu_stall=0, host_gnt=0, rvalid=0, rdata=0.
- CPU read alone (RD_LAT=1): cpu_req=1, we=0, addr=0x10, RAM[0x10]=0xDEADBEEF -> mem_en=1 and mem_addr=0x10 in the same cycle; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF next cycle; host_rvalid stays 0.
- Round-robin: both request continuously for 4 cycles, host burst ending immediately (MAX_BURST=1) -> grant order CPU, host, CPU, host; cpu_stall=1 in cycles 2 and 4.
- Burst cap: host requests 12 words from cycle 0, CPU requests from cycle 3, MAX_BURST=8 -> host_gnt=1 in cycles 0–7, CPU wins cycle 8, host resumes cycle 9; cpu_stall=1 in cycles 3–7.
- Ordered returns (RD_LAT=2): host read 0x20 (=0x1111), then CPU read 0x24 (=0x2222), back-to-back -> host_rvalid with 0x1111 at N+2, cpu_rvalid with 0x2222 at N+3; host_rdata still 0x1111 at N+4.
- Reset mid-read (RD_LAT=2): CPU read granted, reset=0 the next cycle -> no cpu_rvalid at N+2; cpu_rdata=0 after reset.
